// File: rtl/apply_sign_defs.sv
// Shared definitions for the serial sign-application block: state encodings
// and the default data width.
package apply_sign_defs;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_neg_bit.sv
// One bit of LSB-first two's-complement negation: bits are copied up to and
// including the first 1, and every bit after it is inverted.
module serial_neg_bit (
  input  logic in_bit,
  input  logic neg,
  input  logic seen_one,
  output logic out_bit,
  output logic seen_one_next
);

  assign out_bit       = in_bit ^ (neg & seen_one);
  assign seen_one_next = seen_one | in_bit;

endmodule

// File: rtl/apply_sign_serial.sv
// Restores a sign onto an unsigned magnitude, one bit per clock LSB-first,
// producing a two's-complement result plus an overflow flag.
module apply_sign_serial
  import apply_sign_defs::*;
#(
  parameter int width = DEFAULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [width-1:0]        mag,
  input  logic                    is_negative,
  output logic                    busy,
  output logic                    done,
  output logic signed [width-1:0] num_signed,
  output logic                    overflow
);

  // One extra counter bit so the increment past width-1 never wraps.
  localparam int CW = $clog2(width) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(width - 1);

  state_e           state_q, state_d;
  logic [width-1:0] shift_q, shift_d;
  logic [width-1:0] mag_q,   mag_d;
  logic [width-1:0] acc_q,   acc_d;
  logic [width-1:0] num_q,   num_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             sign_q,  sign_d;
  logic             seen_q,  seen_d;
  logic             ovf_q,   ovf_d;

  logic cell_out;
  logic cell_seen;
  logic ovf_calc;

  serial_neg_bit u_cell (
    .in_bit        (shift_q[0]),
    .neg           (sign_q),
    .seen_one      (seen_q),
    .out_bit       (cell_out),
    .seen_one_next (cell_seen)
  );

  // Positive values need a clear MSB; negatives may reach exactly -2**(width-1).
  assign ovf_calc = sign_q ? (mag_q[width-1] & (|mag_q[width-2:0]))
                           : mag_q[width-1];

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    seen_d  = seen_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          shift_d = mag;
          mag_d   = mag;
          sign_d  = is_negative;
          seen_d  = 1'b0;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      ST_SHIFT: begin
        shift_d = shift_q >> 1;
        seen_d  = cell_seen;
        acc_d   = {cell_out, acc_q[width-1:1]};
        cnt_d   = cnt_q + 1'b1;
        // The port only changes here, so partial results never leak out.
        if (cnt_q == LAST_BIT) begin
          state_d = ST_DONE;
          num_d   = {cell_out, acc_q[width-1:1]};
          ovf_d   = ovf_calc;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      mag_q   <= '0;
      acc_q   <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      seen_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      seen_q  <= seen_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy       = (state_q == ST_SHIFT);
  assign done       = (state_q == ST_DONE);
  assign num_signed = num_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_apply_sign_serial.sv
// Directed bench for apply_sign_serial at width 8: timing, held outputs,
// overflow corners, ignored start, mid-run reset and a full magnitude sweep.
module tb_apply_sign_serial;

  localparam int W = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [W-1:0]        mag;
  logic                is_negative;
  logic                busy;
  logic                done;
  logic signed [W-1:0] num_signed;
  logic                overflow;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] held_num;
  logic         held_ovf;

  always #5 clk = ~clk;

  apply_sign_serial #(.width(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mag         (mag),
    .is_negative (is_negative),
    .busy        (busy),
    .done        (done),
    .num_signed  (num_signed),
    .overflow    (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accepts one operation and checks every cycle up to one past done.
  task automatic run(input logic [W-1:0] m, input logic s,
                     input logic [W-1:0] e_num, input logic e_ovf, input string tag);
    exp_q.push_back(e_num);
    mag = m; is_negative = s; start = 1'b1;
    tick();
    start = 1'b0; mag = ~m; is_negative = ~s;
    for (int c = 1; c <= W; c++) begin
      chk({tag, " busy"}, W'(busy), W'(1));
      chk({tag, " early_done"}, W'(done), W'(0));
      chk({tag, " num_held"}, num_signed, held_num);
      tick();
    end
    chk({tag, " done"}, W'(done), W'(1));
    chk({tag, " busy_in_done"}, W'(busy), W'(0));
    chk({tag, " num"}, num_signed, exp_q.pop_front());
    chk({tag, " ovf"}, W'(overflow), W'(e_ovf));
    held_num = e_num; held_ovf = e_ovf;
    tick();
    chk({tag, " done_pulse"}, W'(done), W'(0));
    chk({tag, " num_after"}, num_signed, held_num);
    chk({tag, " ovf_after"}, W'(overflow), W'(held_ovf));
  endtask

  initial begin
    logic [W-1:0] ref_num;
    logic         ref_ovf;
    rst_n = 1'b0; start = 1'b0; mag = '0; is_negative = 1'b0;
    held_num = '0; held_ovf = 1'b0;
    tick(); tick();
    chk("rst busy", W'(busy), W'(0));
    chk("rst done", W'(done), W'(0));
    chk("rst num", num_signed, 8'h00);
    chk("rst ovf", W'(overflow), W'(0));
    rst_n = 1'b1;
    tick();

    run(8'd5,   1'b1, 8'hFB, 1'b0, "neg5");
    run(8'd128, 1'b1, 8'h80, 1'b0, "neg128");
    run(8'd128, 1'b0, 8'h80, 1'b1, "pos128");
    run(8'd200, 1'b1, 8'h38, 1'b1, "neg200");
    run(8'd0,   1'b1, 8'h00, 1'b0, "neg0");
    run(8'd127, 1'b0, 8'h7F, 1'b0, "pos127");
    run(8'd1,   1'b1, 8'hFF, 1'b0, "neg1");

    // start raised mid-run must be ignored; only one done appears
    mag = 8'd7; is_negative = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= W; c++) begin
      if (c == 3) begin start = 1'b1; mag = 8'd9; is_negative = 1'b1; end
      chk("ign busy", W'(busy), W'(1));
      chk("ign early_done", W'(done), W'(0));
      tick();
    end
    start = 1'b0;
    chk("ign done", W'(done), W'(1));
    chk("ign num", num_signed, 8'h07);
    chk("ign ovf", W'(overflow), W'(0));
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("ign no_restart", W'(busy | done), W'(0));
    end
    held_num = 8'h07; held_ovf = 1'b0;

    // reset asserted during cycle 4 of a run discards it
    mag = 8'd5; is_negative = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst busy", W'(busy), W'(0));
    chk("mid_rst done", W'(done), W'(0));
    chk("mid_rst num", num_signed, 8'h00);
    chk("mid_rst ovf", W'(overflow), W'(0));
    rst_n = 1'b1;
    held_num = '0; held_ovf = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("mid_rst no_done", W'(done), W'(0));
    end
    run(8'd3, 1'b1, 8'hFD, 1'b0, "post_rst");

    for (int m = 0; m < 256; m++) begin
      for (int s = 0; s < 2; s++) begin
        ref_num = (s == 1) ? W'(0 - m) : W'(m);
        ref_ovf = (s == 1) ? (m > 128) : (m >= 128);
        run(W'(m), s[0], ref_num, ref_ovf, "sweep");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
